// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
package rr_reg_arbiter_pkg;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // An owner index is never narrower than one bit, even with two requesters.
  function automatic int unsigned owner_width(int unsigned n_req);
    return (n_req > 2) ? int'($clog2(n_req)) : 1;
  endfunction

endpackage

// File: rtl/shared_reg.sv
// Shared storage register: synchronous active-high reset with priority over the write enable.
module shared_reg #(
  parameter int unsigned DataW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [DataW-1:0] d_i,
  output logic [DataW-1:0] q_o
);

  logic [DataW-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter granting bursts of writes into one shared register.
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter int unsigned NReq    = 4,
  parameter int unsigned DataW   = 8,
  parameter int unsigned MaxHold = 4,
  localparam int unsigned OwnerW = owner_width(NReq)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NReq-1:0]       req_i,
  input  logic [NReq-1:0]       last_i,
  input  logic [NReq*DataW-1:0] wdata_i,
  output logic [NReq-1:0]       gnt_o,
  output logic [OwnerW-1:0]     owner_o,
  output logic [DataW-1:0]      q_o,
  output logic                  q_valid_o
);

  localparam int unsigned CntW = $clog2(MaxHold + 1);
  localparam int unsigned SumW = OwnerW + 1;

  state_e            state_q, state_d;
  logic [NReq-1:0]   gnt_q, gnt_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              q_valid_q, q_valid_d;

  logic [2*NReq-1:0] req_sh;
  logic [SumW-1:0]   sum;
  logic [OwnerW-1:0] winner;
  logic              any_req;
  logic [DataW-1:0]  wdata_sel;
  logic [CntW-1:0]   cnt_inc;
  logic              we;

  // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
  always_comb begin
    req_sh  = {req_i, req_i} >> ptr_q;
    any_req = |req_i;
    sum     = '0;
    for (int j = NReq - 1; j >= 0; j--) begin
      if (req_sh[j]) begin
        sum = {1'b0, ptr_q} + SumW'(j);
      end
    end
    if (sum >= SumW'(NReq)) begin
      sum = sum - SumW'(NReq);
    end
    winner = sum[OwnerW-1:0];
  end

  always_comb begin
    wdata_sel = '0;
    for (int i = 0; i < NReq; i++) begin
      if (owner_q == OwnerW'(i)) begin
        wdata_sel = wdata_i[i*DataW +: DataW];
      end
    end
  end

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    q_valid_d = 1'b0;
    we        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d   = NReq'(1) << winner;
          owner_d = winner;
          cnt_d   = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (req_i[owner_q]) begin
          we        = 1'b1;
          q_valid_d = 1'b1;
          cnt_d     = cnt_inc;
        end
        if (!req_i[owner_q] || last_i[owner_q] || (cnt_inc == CntW'(MaxHold))) begin
          gnt_d   = '0;
          state_d = StIdle;
          cnt_d   = '0;
          ptr_d   = (owner_q == OwnerW'(NReq - 1)) ? '0 : owner_q + OwnerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      q_valid_q <= q_valid_d;
    end
  end

  shared_reg #(
    .DataW(DataW)
  ) u_shared_reg (
    .clk (clk),
    .rst (rst),
    .we_i(we),
    .d_i (wdata_sel),
    .q_o (q_o)
  );

  assign gnt_o     = gnt_q;
  assign owner_o   = owner_q;
  assign q_valid_o = q_valid_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter with hand-computed expectations.
module tb_rr_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_reg_arbiter #(
    .NReq   (4),
    .DataW  (8),
    .MaxHold(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .last_i   (last),
    .wdata_i  (wdata),
    .gnt_o    (gnt),
    .owner_o  (owner),
    .q_o      (q),
    .q_valid_o(q_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] o,
                            input logic [7:0] qq, input logic qv);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".owner"}, 32'(owner), 32'(o));
    check({tag, ".q"}, 32'(q), 32'(qq));
    check({tag, ".q_valid"}, 32'(q_valid), 32'(qv));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int order [6] = '{3, 0, 1, 2, 3, 0};
    logic [7:0] lanes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset held with every requester active
    rst = 1'b1; req = 4'b1111; last = 4'b0000; wdata = 32'h0;
    step(); expect_out("rst0", 4'b0000, 2'd0, 8'h00, 1'b0);
    step(); expect_out("rst1", 4'b0000, 2'd0, 8'h00, 1'b0);
    rst = 1'b0;
    step(); expect_out("first_gnt", 4'b0001, 2'd0, 8'h00, 1'b0);
    req = 4'b0000;
    step(); expect_out("drop_nowrite", 4'b0000, 2'd0, 8'h00, 1'b0);
    step();

    // Single burst on requester 2 (ptr is 1)
    req = 4'b0100; wdata = 32'h00A5_0000;
    step(); expect_out("burst_gnt", 4'b0100, 2'd2, 8'h00, 1'b0);
    step(); expect_out("burst_w1", 4'b0100, 2'd2, 8'hA5, 1'b1);
    wdata = 32'h005A_0000; last = 4'b0100;
    step(); expect_out("burst_w2", 4'b0000, 2'd2, 8'h5A, 1'b1);
    req = 4'b0000; last = 4'b0000;
    step(); expect_out("burst_idle", 4'b0000, 2'd2, 8'h5A, 1'b0);

    // Round robin with all requesting, one write each; ptr=3 shows first
    req = 4'b1111; last = 4'b1111; wdata = 32'h4433_2211;
    for (int k = 0; k < 6; k++) begin
      step(); expect_out($sformatf("rr_gnt%0d", k), 4'(1 << order[k]), 2'(order[k]),
                         (k == 0) ? 8'h5A : lanes[order[k-1]], 1'b0);
      step(); expect_out($sformatf("rr_wr%0d", k), 4'b0000, 2'(order[k]),
                         lanes[order[k]], 1'b1);
    end

    // Timeout: requester 1 holds with last low, 3 also requesting (ptr=1)
    req = 4'b1010; last = 4'b0000;
    step(); expect_out("to_gnt", 4'b0010, 2'd1, 8'h11, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wdata = {8'h44, 8'h33, 8'(8'h10 + k), 8'h11};
      step(); expect_out($sformatf("to_wr%0d", k), (k == 3) ? 4'b0000 : 4'b0010, 2'd1,
                         8'(8'h10 + k), 1'b1);
    end
    last = 4'b1000;
    step(); expect_out("to_next3", 4'b1000, 2'd3, 8'h13, 1'b0);
    step(); expect_out("to_wr3", 4'b0000, 2'd3, 8'h44, 1'b1);
    step(); expect_out("to_back1", 4'b0010, 2'd1, 8'h44, 1'b0);
    req = 4'b0000; last = 4'b0000;
    step(); expect_out("to_rel1", 4'b0000, 2'd1, 8'h44, 1'b0);

    // Drop mid-burst on requester 0 (ptr=2)
    req = 4'b0001;
    step(); expect_out("dr_gnt", 4'b0001, 2'd0, 8'h44, 1'b0);
    wdata = 32'h0000_00C1;
    step(); expect_out("dr_w1", 4'b0001, 2'd0, 8'hC1, 1'b1);
    wdata = 32'h0000_00C2;
    step(); expect_out("dr_w2", 4'b0001, 2'd0, 8'hC2, 1'b1);
    req = 4'b0000; wdata = 32'h0000_00C3;
    step(); expect_out("dr_rel", 4'b0000, 2'd0, 8'hC2, 1'b0);

    // Reset during the second write of a burst (ptr=1)
    req = 4'b0100; wdata = 32'h0077_0000;
    step(); expect_out("mr_gnt", 4'b0100, 2'd2, 8'hC2, 1'b0);
    step(); expect_out("mr_w1", 4'b0100, 2'd2, 8'h77, 1'b1);
    rst = 1'b1; wdata = 32'h0088_0000;
    step(); expect_out("mr_rst", 4'b0000, 2'd0, 8'h00, 1'b0);
    rst = 1'b0; req = 4'b1111;
    step(); expect_out("mr_ptr0", 4'b0001, 2'd0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
